// File: rtl/phy_rx_deframer_pkg.sv
// Shared definitions for the GT receive deframer:
// control codes, K masks, state encoding and lane helpers.
package phy_rx_deframer_pkg;

   localparam logic [7:0] K_COMMA = 8'hBC;
   localparam logic [7:0] K_ALIGN = 8'h50;
   localparam logic [7:0] K_SOF   = 8'hFB;
   localparam logic [7:0] K_EOF   = 8'hFD;

   localparam logic [3:0] COMMA_KMASK = 4'b1010;
   localparam logic [3:0] SOF_KMASK   = 4'b1000;

   localparam logic [31:0] COMMA_WORD =
      {K_COMMA, K_ALIGN, K_COMMA, K_ALIGN};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SOF,
      ST_DATA,
      ST_TAIL
   } state_t;

   function automatic logic [31:0] byte_rev(
      input logic [31:0] d
   );
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [3:0] bit_rev4(
      input logic [3:0] k
   );
      return {k[0], k[1], k[2], k[3]};
   endfunction

endpackage

// File: rtl/phy_rx_eof_decode.sv
// Finds the first K byte of a lane-reversed word and
// classifies it as end-of-frame (with position) or error.
module phy_rx_eof_decode
   import phy_rx_deframer_pkg::*;
(
   input  logic [3:0]  k,
   input  logic [31:0] w,
   output logic        is_eof,
   output logic [1:0]  p,
   output logic        err
);

   logic [7:0] kbyte;

   // Bytes after the first K byte are filler.
   always_comb begin
      p     = 2'd0;
      kbyte = w[31:24];
      casez (k)
         4'b1???: begin
            p     = 2'd0;
            kbyte = w[31:24];
         end
         4'b01??: begin
            p     = 2'd1;
            kbyte = w[23:16];
         end
         4'b001?: begin
            p     = 2'd2;
            kbyte = w[15:8];
         end
         4'b0001: begin
            p     = 2'd3;
            kbyte = w[7:0];
         end
         default: ;
      endcase
      is_eof = (k != 4'b0000) && (kbyte == K_EOF);
      err    = (k != 4'b0000) && !is_eof;
   end

endmodule

// File: rtl/phy_rx_deframer.sv
// GT receive deframer: comma/SOF hunt, payload realignment
// to MSB-first AXI-Stream words, EOF/abort, link watchdog.
module phy_rx_deframer
   import phy_rx_deframer_pkg::*;
#(
   parameter int P_MAX_WORDS    = 1024,
   parameter int P_LINK_TIMEOUT = 2048
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_gt_rx_done,
   input  logic [31:0] i_gt_rx_data,
   input  logic [3:0]  i_gt_rx_char,
   output logic [31:0] o_rx_axis_data,
   output logic [3:0]  o_rx_axis_keep,
   output logic        o_rx_axis_valid,
   output logic        o_rx_axis_last,
   output logic        o_rx_axis_user,
   output logic        o_link_up,
   output logic [15:0] o_frame_cnt,
   output logic [15:0] o_err_cnt
);

   localparam int CW = $clog2(P_MAX_WORDS + 1);
   localparam int TW = $clog2(P_LINK_TIMEOUT + 1);

   logic [31:0]   w_q;
   logic [3:0]    k_q;
   logic          done_q;
   logic [23:0]   prev;
   logic [1:0]    tail_p;
   logic [CW-1:0] word_cnt;
   logic [TW-1:0] timer;

   state_t state;
   state_t state_nxt;

   logic       is_comma;
   logic       is_sof;
   logic       k_eof;
   logic       k_err;
   logic [1:0] eof_p;
   logic       link_fall;
   logic       emit;
   logic       abort;

   logic [31:0] data_nxt;
   logic [3:0]  keep_nxt;
   logic        valid_nxt;
   logic        last_nxt;
   logic        user_nxt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         w_q    <= '0;
         k_q    <= '0;
         done_q <= 1'b0;
      end else begin
         w_q    <= byte_rev(i_gt_rx_data);
         k_q    <= bit_rev4(i_gt_rx_char);
         done_q <= i_gt_rx_done;
      end
   end

   assign is_comma = (w_q == COMMA_WORD) &&
                     (k_q == COMMA_KMASK);
   assign is_sof   = (k_q == SOF_KMASK) &&
                     (w_q[31:24] == K_SOF);

   phy_rx_eof_decode u_eof (
      .k      (k_q),
      .w      (w_q),
      .is_eof (k_eof),
      .p      (eof_p),
      .err    (k_err)
   );

   assign link_fall = o_link_up && (timer == '0) &&
                      !is_comma;
   assign emit      = (k_q == 4'b0000) || k_eof;
   assign abort     = (state == ST_DATA) &&
                      (!done_q || link_fall || k_err ||
                       (emit &&
                        (word_cnt == CW'(P_MAX_WORDS))));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         timer     <= '0;
         o_link_up <= 1'b0;
      end else if (is_comma) begin
         timer     <= TW'(P_LINK_TIMEOUT - 1);
         o_link_up <= 1'b1;
      end else if (timer != '0) begin
         timer <= timer - 1'b1;
      end else begin
         o_link_up <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:
            if (is_comma) state_nxt = ST_SOF;
         ST_SOF:
            if (is_sof)         state_nxt = ST_DATA;
            else if (!is_comma) state_nxt = ST_IDLE;
         ST_DATA:
            if (abort)
               state_nxt = ST_IDLE;
            else if (k_eof)
               state_nxt = eof_p[1] ? ST_TAIL : ST_IDLE;
         ST_TAIL:
            state_nxt = ST_IDLE;
      endcase
      if (!done_q) state_nxt = ST_IDLE;
   end

   // Each word joins the previous three bytes with the
   // current leading byte; the tail drains the rest.
   always_comb begin
      data_nxt  = '0;
      keep_nxt  = '0;
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
      user_nxt  = 1'b0;
      unique case (state)
         ST_DATA: begin
            valid_nxt = 1'b1;
            keep_nxt  = 4'b1111;
            if (abort) begin
               last_nxt = 1'b1;
               user_nxt = 1'b1;
            end else if (k_q == 4'b0000) begin
               data_nxt = {prev, w_q[31:24]};
            end else if (eof_p == 2'd0) begin
               data_nxt = {prev, 8'h00};
               keep_nxt = 4'b1110;
               last_nxt = 1'b1;
            end else begin
               data_nxt = {prev, w_q[31:24]};
               last_nxt = !eof_p[1];
            end
         end
         ST_TAIL: begin
            valid_nxt = 1'b1;
            last_nxt  = 1'b1;
            if (tail_p[0]) begin
               data_nxt = {prev[23:8], 16'h0000};
               keep_nxt = 4'b1100;
            end else begin
               data_nxt = {prev[23:16], 24'h000000};
               keep_nxt = 4'b1000;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         prev            <= '0;
         tail_p          <= '0;
         word_cnt        <= '0;
         o_rx_axis_data  <= '0;
         o_rx_axis_keep  <= '0;
         o_rx_axis_valid <= 1'b0;
         o_rx_axis_last  <= 1'b0;
         o_rx_axis_user  <= 1'b0;
         o_frame_cnt     <= '0;
         o_err_cnt       <= '0;
      end else begin
         prev            <= w_q[23:0];
         tail_p          <= eof_p;
         o_rx_axis_data  <= data_nxt;
         o_rx_axis_keep  <= keep_nxt;
         o_rx_axis_valid <= valid_nxt;
         o_rx_axis_last  <= last_nxt;
         o_rx_axis_user  <= user_nxt;
         if (state != ST_DATA)
            word_cnt <= '0;
         else if (emit && !abort)
            word_cnt <= word_cnt + 1'b1;
         if (valid_nxt && last_nxt && !user_nxt &&
             (o_frame_cnt != 16'hFFFF))
            o_frame_cnt <= o_frame_cnt + 1'b1;
         if (abort && (o_err_cnt != 16'hFFFF))
            o_err_cnt <= o_err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Scenario bench for phy_rx_deframer: expected words are
// queued at drive time and popped as the DUT emits them.
module tb_phy_rx_deframer;

   localparam int MAXW = 4;
   localparam int LTO  = 40;
   localparam logic [31:0] IDLE_W = 32'h07070707;
   localparam logic [31:0] COMMA  = 32'hBC50BC50;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_gt_rx_done = 1'b0;
   logic [31:0] i_gt_rx_data = '0;
   logic [3:0]  i_gt_rx_char = '0;
   logic [31:0] o_rx_axis_data;
   logic [3:0]  o_rx_axis_keep;
   logic        o_rx_axis_valid;
   logic        o_rx_axis_last;
   logic        o_rx_axis_user;
   logic        o_link_up;
   logic [15:0] o_frame_cnt;
   logic [15:0] o_err_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int dcyc  = 0;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  keep;
      logic        last;
      logic        user;
      int          at;
   } exp_t;

   exp_t sb[$];

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   phy_rx_deframer #(
      .P_MAX_WORDS    (MAXW),
      .P_LINK_TIMEOUT (LTO)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_gt_rx_done    (i_gt_rx_done),
      .i_gt_rx_data    (i_gt_rx_data),
      .i_gt_rx_char    (i_gt_rx_char),
      .o_rx_axis_data  (o_rx_axis_data),
      .o_rx_axis_keep  (o_rx_axis_keep),
      .o_rx_axis_valid (o_rx_axis_valid),
      .o_rx_axis_last  (o_rx_axis_last),
      .o_rx_axis_user  (o_rx_axis_user),
      .o_link_up       (o_link_up),
      .o_frame_cnt     (o_frame_cnt),
      .o_err_cnt       (o_err_cnt)
   );

   // w/k given first-byte-first; the wire puts it in lane 0.
   task automatic drive(input logic [31:0] w,
                        input logic [3:0] k);
      @(posedge i_clk);
      #1;
      i_gt_rx_data = {w[7:0], w[15:8], w[23:16], w[31:24]};
      i_gt_rx_char = {k[0], k[1], k[2], k[3]};
      dcyc = cyc;
   endtask

   task automatic sample();
      exp_t e;
      @(negedge i_clk);
      if (!i_rst && o_rx_axis_valid) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL word_unexpected cyc=%0d got data=%h keep=%b last=%b user=%b required none",
                     cyc, o_rx_axis_data, o_rx_axis_keep,
                     o_rx_axis_last, o_rx_axis_user);
         end else begin
            e = sb.pop_front();
            if (o_rx_axis_data !== e.d ||
                o_rx_axis_keep !== e.keep ||
                o_rx_axis_last !== e.last ||
                o_rx_axis_user !== e.user ||
                cyc != e.at) begin
               bad++;
               $display("FAIL word cyc=%0d got data=%h keep=%b last=%b user=%b required data=%h keep=%b last=%b user=%b cyc=%0d",
                        cyc, o_rx_axis_data, o_rx_axis_keep,
                        o_rx_axis_last, o_rx_axis_user,
                        e.d, e.keep, e.last, e.user, e.at);
            end
         end
      end
   endtask

   task automatic tick(input logic [31:0] w,
                       input logic [3:0] k);
      sample();
      drive(w, k);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(IDLE_W, 4'b0000);
   endtask

   task automatic push_exp(input logic [31:0] d,
                           input logic [3:0] keep,
                           input logic last,
                           input logic user,
                           input int lat);
      exp_t e;
      e.d    = d;
      e.keep = keep;
      e.last = last;
      e.user = user;
      e.at   = dcyc + lat;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      #1 i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      total++;
      if (o_rx_axis_data !== 32'h0) begin
         bad++;
         $display("FAIL rst_data got=%h required=0", o_rx_axis_data);
      end
      total++;
      if (o_rx_axis_keep !== 4'h0) begin
         bad++;
         $display("FAIL rst_keep got=%b required=0000", o_rx_axis_keep);
      end
      total++;
      if (o_rx_axis_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_valid got=%b required=0", o_rx_axis_valid);
      end
      total++;
      if (o_rx_axis_last !== 1'b0) begin
         bad++;
         $display("FAIL rst_last got=%b required=0", o_rx_axis_last);
      end
      total++;
      if (o_rx_axis_user !== 1'b0) begin
         bad++;
         $display("FAIL rst_user got=%b required=0", o_rx_axis_user);
      end
      total++;
      if (o_link_up !== 1'b0) begin
         bad++;
         $display("FAIL rst_link got=%b required=0", o_link_up);
      end
      total++;
      if (o_frame_cnt !== 16'h0) begin
         bad++;
         $display("FAIL rst_frame_cnt got=%0d required=0", o_frame_cnt);
      end
      total++;
      if (o_err_cnt !== 16'h0) begin
         bad++;
         $display("FAIL rst_err_cnt got=%0d required=0", o_err_cnt);
      end
      drive(IDLE_W, 4'b0000);
      i_rst = 1'b0;
      i_gt_rx_done = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      tick(COMMA, 4'b1010);
      tick(32'hFBAABBCC, 4'b1000);
      tick(32'hDDEEFF00, 4'b0000);
      push_exp(32'hAABBCCDD, 4'b1111, 1'b0, 1'b0, 2);
      tick(32'h11FD0707, 4'b0100);
      push_exp(32'hEEFF0011, 4'b1111, 1'b1, 1'b0, 2);
      idle(4);
      total++;
      if (o_frame_cnt !== 16'd1) begin
         bad++;
         $display("FAIL basic_frame_cnt got=%0d required=1", o_frame_cnt);
      end
      total++;
      if (o_link_up !== 1'b1) begin
         bad++;
         $display("FAIL basic_link got=%b required=1", o_link_up);
      end
   endtask

   task automatic test_eof_sweep();
      logic [31:0] ew;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 4; i++)
            ew[31-8*i -: 8] = (i < p) ? 8'(8'h10 + i) :
                              (i == p) ? 8'hFD : 8'h07;
         tick(COMMA, 4'b1010);
         tick(32'hFB010203, 4'b1000);
         tick(32'h04050607, 4'b0000);
         push_exp(32'h01020304, 4'b1111, 1'b0, 1'b0, 2);
         tick(ew, 4'b1000 >> p);
         case (p)
            0: push_exp({24'h050607, 8'h00}, 4'b1110,
                        1'b1, 1'b0, 2);
            1: push_exp({24'h050607, ew[31:24]}, 4'b1111,
                        1'b1, 1'b0, 2);
            2: begin
               push_exp({24'h050607, ew[31:24]}, 4'b1111,
                        1'b0, 1'b0, 2);
               push_exp({ew[23:16], 24'h0}, 4'b1000,
                        1'b1, 1'b0, 3);
            end
            default: begin
               push_exp({24'h050607, ew[31:24]}, 4'b1111,
                        1'b0, 1'b0, 2);
               push_exp({ew[23:8], 16'h0}, 4'b1100,
                        1'b1, 1'b0, 3);
            end
         endcase
         idle(4);
         total++;
         if (o_frame_cnt !== 16'(2 + p)) begin
            bad++;
            $display("FAIL sweep_frame_cnt p=%0d got=%0d required=%0d",
                     p, o_frame_cnt, 2 + p);
         end
      end
   endtask

   task automatic test_short_frame();
      tick(COMMA, 4'b1010);
      tick(32'hFBAABBCC, 4'b1000);
      tick(32'hFD070707, 4'b1000);
      push_exp(32'hAABBCC00, 4'b1110, 1'b1, 1'b0, 2);
      idle(4);
      total++;
      if (o_frame_cnt !== 16'd6) begin
         bad++;
         $display("FAIL short_frame_cnt got=%0d required=6", o_frame_cnt);
      end
   endtask

   task automatic test_kerr();
      tick(COMMA, 4'b1010);
      tick(32'hFB010203, 4'b1000);
      tick(32'h04050607, 4'b0000);
      push_exp(32'h01020304, 4'b1111, 1'b0, 1'b0, 2);
      tick(32'h08090A0B, 4'b0100);
      push_exp(32'h0, 4'b1111, 1'b1, 1'b1, 2);
      idle(4);
      total++;
      if (o_err_cnt !== 16'd1) begin
         bad++;
         $display("FAIL kerr_err_cnt got=%0d required=1", o_err_cnt);
      end
      tick(COMMA, 4'b1010);
      tick(32'hFB313233, 4'b1000);
      tick(32'h34353637, 4'b0000);
      push_exp(32'h31323334, 4'b1111, 1'b0, 1'b0, 2);
      tick(32'h38FD0000, 4'b0100);
      push_exp(32'h35363738, 4'b1111, 1'b1, 1'b0, 2);
      idle(4);
      total++;
      if (o_frame_cnt !== 16'd7) begin
         bad++;
         $display("FAIL kerr_frame_cnt got=%0d required=7", o_frame_cnt);
      end
   endtask

   task automatic test_max_words();
      logic [23:0] prev;
      logic [31:0] d;
      tick(COMMA, 4'b1010);
      tick(32'hFB010203, 4'b1000);
      prev = 24'h010203;
      for (int i = 0; i < 6; i++) begin
         d = 32'h20212223 + 32'(i) * 32'h04040404;
         tick(d, 4'b0000);
         if (i < MAXW)
            push_exp({prev, d[31:24]}, 4'b1111,
                     1'b0, 1'b0, 2);
         else if (i == MAXW)
            push_exp(32'h0, 4'b1111, 1'b1, 1'b1, 2);
         prev = d[23:0];
      end
      tick(32'h50FD0707, 4'b0100);
      idle(4);
      total++;
      if (o_err_cnt !== 16'd2) begin
         bad++;
         $display("FAIL max_err_cnt got=%0d required=2", o_err_cnt);
      end
      total++;
      if (o_frame_cnt !== 16'd7) begin
         bad++;
         $display("FAIL max_frame_cnt got=%0d required=7", o_frame_cnt);
      end
   endtask

   task automatic test_link();
      tick(COMMA, 4'b1010);
      idle(LTO + 1);
      total++;
      if (o_link_up !== 1'b1) begin
         bad++;
         $display("FAIL link_hold got=%b required=1", o_link_up);
      end
      idle(1);
      total++;
      if (o_link_up !== 1'b0) begin
         bad++;
         $display("FAIL link_timeout got=%b required=0", o_link_up);
      end
      idle(5);
      tick(COMMA, 4'b1010);
      idle(1);
      total++;
      if (o_link_up !== 1'b0) begin
         bad++;
         $display("FAIL link_early got=%b required=0", o_link_up);
      end
      idle(1);
      total++;
      if (o_link_up !== 1'b1) begin
         bad++;
         $display("FAIL link_rise got=%b required=1", o_link_up);
      end
   endtask

   task automatic test_reset_mid();
      tick(COMMA, 4'b1010);
      tick(32'hFB010203, 4'b1000);
      tick(32'h04050607, 4'b0000);
      push_exp(32'h01020304, 4'b1111, 1'b0, 1'b0, 2);
      tick(32'h08090A0B, 4'b0000);
      tick(IDLE_W, 4'b0000);
      sample();
      #1 i_rst = 1'b1;
      #1;
      total++;
      if ({o_rx_axis_data, o_rx_axis_keep, o_rx_axis_valid,
           o_rx_axis_last, o_rx_axis_user, o_link_up,
           o_frame_cnt, o_err_cnt} !== '0) begin
         bad++;
         $display("FAIL midrst_outputs got data=%h keep=%b valid=%b last=%b link=%b frames=%0d errs=%0d required all 0",
                  o_rx_axis_data, o_rx_axis_keep,
                  o_rx_axis_valid, o_rx_axis_last, o_link_up,
                  o_frame_cnt, o_err_cnt);
      end
      idle(2);
      i_rst = 1'b0;
      tick(32'hFB414243, 4'b1000);
      tick(32'h44454647, 4'b0000);
      tick(32'h48FD0707, 4'b0100);
      idle(3);
      tick(COMMA, 4'b1010);
      tick(32'hFB515253, 4'b1000);
      tick(32'h54555657, 4'b0000);
      push_exp(32'h51525354, 4'b1111, 1'b0, 1'b0, 2);
      tick(32'h58595AFD, 4'b0001);
      push_exp(32'h55565758, 4'b1111, 1'b0, 1'b0, 2);
      push_exp(32'h595A0000, 4'b1100, 1'b1, 1'b0, 3);
      idle(4);
      total++;
      if (o_frame_cnt !== 16'd1 || o_err_cnt !== 16'd0) begin
         bad++;
         $display("FAIL midrst_counts got frames=%0d errs=%0d required frames=1 errs=0",
                  o_frame_cnt, o_err_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_eof_sweep();
      test_short_frame();
      test_kerr();
      test_max_words();
      test_link();
      test_reset_mid();
      idle(6);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL pending_words got=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "bench did not finish");
   end

endmodule
